// File: rtl/fir_coeff_scheduler.sv
// rtl/fir_coeff_scheduler.sv - double-buffered FIR coefficient loader driven by a toggle-handshake command register
// Optional macro FIR_COEFF_SCHED_STATUS_EN builds the status readback and dropped-command counter.
module fir_coeff_scheduler #(
  parameter int ADDR_W = 5,
  parameter int COEF_W = 16
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       reg_data,
  input  logic              sync_in,
  output logic              coef_we,
  output logic              coef_bank,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [COEF_W-1:0] coef_data,
  output logic              active_bank,
  output logic              busy,
  output logic [31:0]       status
);

  localparam int N_TAPS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_CLEAR     = 2'd2,
    S_WAIT_SYNC = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         reg_q;
  logic                prev_tgl_q;
  logic                smp_vld_q;
  logic                primed_q;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [COEF_W-1:0]   cmd_data_q, cmd_data_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                coef_we_q, coef_we_d;
  logic [ADDR_W-1:0]   coef_addr_q, coef_addr_d;
  logic [COEF_W-1:0]   coef_data_q, coef_data_d;
  logic                active_bank_q, active_bank_d;
  logic                cmd_det;
  logic                cmd_drop;
  logic                unused_bits;

  // primed_q only rises once prev_tgl_q holds a real sample, so the value present at reset release never counts as a toggle
  assign cmd_det     = primed_q && (reg_q[31] != prev_tgl_q);
  assign cmd_drop    = cmd_det && (state_q != S_IDLE);
  assign unused_bits = ^reg_q;

  always_comb begin
    state_d       = state_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    clr_cnt_d     = clr_cnt_q;
    coef_we_d     = 1'b0;
    coef_addr_d   = coef_addr_q;
    coef_data_d   = coef_data_q;
    active_bank_d = active_bank_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_det) begin
          case (reg_q[30:29])
            2'b01: begin
              state_d    = S_WRITE;
              cmd_addr_d = reg_q[16 +: ADDR_W];
              cmd_data_d = reg_q[0 +: COEF_W];
            end
            2'b10: begin
              state_d   = S_CLEAR;
              clr_cnt_d = '0;
            end
            2'b11:   state_d = S_WAIT_SYNC;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WRITE: begin
        coef_we_d   = 1'b1;
        coef_addr_d = cmd_addr_q;
        coef_data_d = cmd_data_q;
        state_d     = S_IDLE;
      end
      S_CLEAR: begin
        coef_we_d   = 1'b1;
        coef_addr_d = clr_cnt_q;
        coef_data_d = '0;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(N_TAPS - 1)) state_d = S_IDLE;
      end
      S_WAIT_SYNC: begin
        if (sync_in) begin
          active_bank_d = ~active_bank_q;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q       <= S_IDLE;
      reg_q         <= '0;
      prev_tgl_q    <= 1'b0;
      smp_vld_q     <= 1'b0;
      primed_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      clr_cnt_q     <= '0;
      coef_we_q     <= 1'b0;
      coef_addr_q   <= '0;
      coef_data_q   <= '0;
      active_bank_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      reg_q         <= reg_data;
      prev_tgl_q    <= reg_q[31];
      smp_vld_q     <= 1'b1;
      primed_q      <= smp_vld_q;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      clr_cnt_q     <= clr_cnt_d;
      coef_we_q     <= coef_we_d;
      coef_addr_q   <= coef_addr_d;
      coef_data_q   <= coef_data_d;
      active_bank_q <= active_bank_d;
    end
  end

  assign coef_we     = coef_we_q;
  assign coef_addr   = coef_addr_q;
  assign coef_data   = coef_data_q;
  assign active_bank = active_bank_q;
  assign coef_bank   = ~active_bank_q;
  assign busy        = (state_q != S_IDLE);

`ifdef FIR_COEFF_SCHED_STATUS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (cmd_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) drop_cnt_q <= '0;
    else             drop_cnt_q <= drop_cnt_d;
  end

  assign status = {busy, active_bank_q, state_q, 12'b0, drop_cnt_q};
`else
  logic unused_drop;
  assign unused_drop = cmd_drop;
  assign status      = '0;
`endif

endmodule

// File: tb/tb_fir_coeff_scheduler.sv
// tb/tb_fir_coeff_scheduler.sv - directed scoreboard bench for fir_coeff_scheduler
module tb_fir_coeff_scheduler;

  localparam int ADDR_W = 5;
  localparam int COEF_W = 16;
  localparam int N_TAPS = 32;

  logic              user_clk = 1'b0;
  logic              user_rst_n;
  logic [31:0]       reg_data;
  logic              sync_in;
  logic              coef_we;
  logic              coef_bank;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              active_bank;
  logic              busy;
  logic [31:0]       status;

  fir_coeff_scheduler #(.ADDR_W(ADDR_W), .COEF_W(COEF_W)) dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .reg_data    (reg_data),
    .sync_in     (sync_in),
    .coef_we     (coef_we),
    .coef_bank   (coef_bank),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .active_bank (active_bank),
    .busy        (busy),
    .status      (status)
  );

  always #5 user_clk = ~user_clk;

  typedef struct packed {
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic [COEF_W-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge user_clk) begin
    wr_t e;
    if (coef_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {31'b0, coef_we}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_addr", {27'b0, coef_addr}, {27'b0, e.addr});
        check("sb_data", {16'b0, coef_data}, {16'b0, e.data});
        check("sb_bank", {31'b0, coef_bank}, {31'b0, e.bank});
      end
    end
  end

  initial begin
    logic [31:0] exp_stat;
    user_rst_n = 1'b0;
    reg_data   = 32'hA000_0000;
    sync_in    = 1'b0;
    repeat (2) @(negedge user_clk);
    check("rst_we",     {31'b0, coef_we}, 32'd0);
    check("rst_bank",   {31'b0, coef_bank}, 32'd1);
    check("rst_addr",   {27'b0, coef_addr}, 32'd0);
    check("rst_data",   {16'b0, coef_data}, 32'd0);
    check("rst_active", {31'b0, active_bank}, 32'd0);
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_status", status, 32'd0);

    user_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge user_clk);
      check("release_we",   {31'b0, coef_we}, 32'd0);
      check("release_busy", {31'b0, busy}, 32'd0);
    end

    reg_data = 32'h2005_1234;
    sb.push_back(wr_t'{1'b1, 5'd5, 16'h1234});
    @(negedge user_clk);
    check("wr_we_e0", {31'b0, coef_we}, 32'd0);
    @(negedge user_clk);
    check("wr_we_e1", {31'b0, coef_we}, 32'd0);
    check("wr_busy",  {31'b0, busy}, 32'd1);
    @(negedge user_clk);
    check("wr_we_e2", {31'b0, coef_we}, 32'd1);
    @(negedge user_clk);
    check("wr_we_one_cycle", {31'b0, coef_we}, 32'd0);
    check("wr_idle",         {31'b0, busy}, 32'd0);
    repeat (3) @(negedge user_clk);
    check("hold_addr", {27'b0, coef_addr}, 32'd5);
    check("hold_data", {16'b0, coef_data}, 32'h1234);

    reg_data = 32'hC000_0000;
    for (int i = 0; i < N_TAPS; i++) sb.push_back(wr_t'{1'b1, ADDR_W'(i), 16'h0000});
    repeat (2) @(negedge user_clk);
    reg_data = 32'h2003_BEEF;
    for (int i = 0; i < N_TAPS; i++) begin
      @(negedge user_clk);
      check("clear_we", {31'b0, coef_we}, 32'd1);
    end
    @(negedge user_clk);
    check("clear_done_we", {31'b0, coef_we}, 32'd0);
    check("clear_busy",    {31'b0, busy}, 32'd0);
    check("clear_sb_empty", sb.size(), 32'd0);
`ifdef FIR_COEFF_SCHED_STATUS_EN
    exp_stat = 32'h0000_0001;
`else
    exp_stat = 32'h0000_0000;
`endif
    check("drop_status", status, exp_stat);

    reg_data = 32'hE000_0000;
    @(negedge user_clk);
    sync_in = 1'b1;
    @(negedge user_clk);
    sync_in = 1'b0;
    check("commit_busy",      {31'b0, busy}, 32'd1);
    check("commit_early_swap", {31'b0, active_bank}, 32'd0);
    repeat (9) @(negedge user_clk);
    check("wait_busy", {31'b0, busy}, 32'd1);
    check("wait_bank", {31'b0, active_bank}, 32'd0);
`ifdef FIR_COEFF_SCHED_STATUS_EN
    exp_stat = 32'hB000_0001;
`else
    exp_stat = 32'h0000_0000;
`endif
    check("wait_status", status, exp_stat);
    sync_in = 1'b1;
    @(negedge user_clk);
    sync_in = 1'b0;
    check("swap_active",    {31'b0, active_bank}, 32'd1);
    check("swap_coef_bank", {31'b0, coef_bank}, 32'd0);
    check("swap_idle",      {31'b0, busy}, 32'd0);

    sync_in = 1'b1;
    @(negedge user_clk);
    sync_in = 1'b0;
    @(negedge user_clk);
    check("stray_sync", {31'b0, active_bank}, 32'd1);

    reg_data = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge user_clk);
      check("nop_busy", {31'b0, busy}, 32'd0);
    end

    reg_data = 32'hC000_0000;
    for (int i = 0; i <= 10; i++) sb.push_back(wr_t'{1'b0, ADDR_W'(i), 16'h0000});
    repeat (13) @(negedge user_clk);
    check("abort_at_we",   {31'b0, coef_we}, 32'd1);
    check("abort_at_addr", {27'b0, coef_addr}, 32'd10);
    #2 user_rst_n = 1'b0;
    #1;
    check("abort_we",     {31'b0, coef_we}, 32'd0);
    check("abort_active", {31'b0, active_bank}, 32'd0);
    check("abort_bank",   {31'b0, coef_bank}, 32'd1);
    check("abort_busy",   {31'b0, busy}, 32'd0);
    repeat (2) @(negedge user_clk);
    user_rst_n = 1'b1;
    repeat (40) @(negedge user_clk);
    check("abort_sb_empty", sb.size(), 32'd0);
    check("abort_active_after", {31'b0, active_bank}, 32'd0);
    check("abort_busy_after",   {31'b0, busy}, 32'd0);

    reg_data = 32'h201F_FFFF;
    sb.push_back(wr_t'{1'b1, 5'd31, 16'hFFFF});
    repeat (3) @(negedge user_clk);
    check("last_addr_we", {31'b0, coef_we}, 32'd1);
    @(negedge user_clk);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_scheduler.md
FIR_COEFF_SCHEDULER -- requirements
Module: fir_coeff_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: coefficient address width; N_TAPS = 2^ADDR_W.
REQ-002 SHALL have parameter COEF_W, default 16: coefficient width, at most 16.
REQ-003 SHALL have port user_clk, input, 1: sole clock.
REQ-004 SHALL have port user_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port reg_data, input, 32: software command word from the PPC-to-fabric register.
REQ-006 SHALL have port sync_in, input, 1: frame sync; one-cycle pulse.
REQ-007 SHALL have port coef_we, output, 1: coefficient RAM write strobe.
REQ-008 SHALL have port coef_bank, output, 1: RAM bank written, always the shadow bank (~active_bank).
REQ-009 SHALL have port coef_addr, output, ADDR_W: coefficient RAM write address.
REQ-010 SHALL have port coef_data, output, COEF_W: coefficient RAM write data.
REQ-011 SHALL have port active_bank, output, 1: bank used by the FIR datapath.
REQ-012 SHALL have port busy, output, 1: high when the FSM is not in IDLE.
REQ-013 SHALL have port status, output, 32: readback word for the fabric-to-PPC register.

Function
REQ-014 reg_data field map: [31] toggle, [30:29] op (00 NOP, 01 WRITE, 10 CLEAR, 11 COMMIT), [23:16] address (low ADDR_W bits used), [15:0] data (low COEF_W bits used).
REQ-015 SHALL register reg_data once; a command SHALL be any change of the registered bit 31 versus its previous registered value.
REQ-016 The first registered sample after reset SHALL only load the previous-value register and SHALL NOT issue a command.
REQ-017 FSM states SHALL be IDLE, WRITE, CLEAR and WAIT_SYNC.
REQ-018 Commands SHALL be accepted only in IDLE; a command detected in any other state SHALL be dropped.
REQ-019 WRITE SHALL assert coef_we for exactly 1 cycle with the command's address and data, then return to IDLE.
REQ-020 Latency from reg_data toggling before clock edge E0 to coef_we high SHALL be 2 cycles (coef_we valid after edge E0+2).
REQ-021 CLEAR SHALL write data 0 to addresses 0 through N_TAPS-1, one per cycle, with coef_we continuously high, then return to IDLE.
REQ-022 COMMIT SHALL enter WAIT_SYNC; on the first edge at which sync_in is sampled high in WAIT_SYNC, active_bank SHALL toggle and the FSM SHALL return to IDLE.
REQ-023 A sync_in pulse in the same cycle as COMMIT detection SHALL be ignored; the swap SHALL occur on the next pulse.
REQ-024 sync_in outside WAIT_SYNC SHALL have no effect.
REQ-025 NOP SHALL be consumed with no output activity.
REQ-026 coef_addr and coef_data SHALL hold their last values when coef_we is low.

Reset
REQ-027 Assertion of user_rst_n low SHALL immediately force the FSM to IDLE and all outputs to 0, with active_bank 0 and coef_bank 1.
REQ-028 A reset during CLEAR or WAIT_SYNC SHALL abort the operation with no further writes and no swap.
REQ-029 The drop counter and the toggle history SHALL clear on reset.

Configuration
REQ-030 With macro FIR_COEFF_SCHED_STATUS_EN defined, status SHALL be {busy, active_bank, FSM state[1:0], 12'b0, 16-bit saturating dropped-command count}.
REQ-031 Without FIR_COEFF_SCHED_STATUS_EN, status SHALL be constant 0 and no drop counter SHALL be built.

Verification
REQ-032 Release reset with reg_data = 0xA000_0000 held -> no coef_we and busy stays 0.
REQ-033 Toggle to 0x2005_1234 -> coef_we high for 1 cycle at E0+2, coef_addr 5, coef_data 0x1234, coef_bank 1.
REQ-034 Issue CLEAR, then WRITE 2 cycles later -> 32 consecutive writes of addresses 0..31 with data 0; the WRITE is dropped and the status drop count is 1 (macro defined).
REQ-035 Issue COMMIT with sync_in pulsed in the detection cycle and again 10 cycles later -> active_bank flips only at the second pulse; busy is high during the wait.
REQ-036 Pull user_rst_n low at CLEAR address 10 -> coef_we drops 0 asynchronously, no writes follow after release, and active_bank is 0.
